// File: rtl/pl_muldiv_unit_if.sv
// Operand/result bundle between the EX stage and the iterative multiply/divide unit.
interface pl_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [4:0]      rd_in;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic [4:0]      rd_out;

  modport master (
    output start, flush, funct3, rd_in, op_a, op_b,
    input  busy, stall, done, result, rd_out
  );

  modport slave (
    input  start, flush, funct3, rd_in, op_a, op_b,
    output busy, stall, done, result, rd_out
  );
endinterface

// File: rtl/pl_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes with a final sign-fix cycle.
module pl_muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  pl_muldiv_unit_if.slave   bus
);
  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             pick_hi_q, pick_hi_d;
  logic [4:0]       rd_q, rd_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [4:0]       rd_out_q, rd_out_d;
  logic             done_q, done_d;

  // Operand decode at issue: signedness, magnitudes and fast-path detection.
  logic            in_signed_a, in_signed_b, in_sign_a, in_sign_b;
  logic            in_div, in_div0, in_ovf;
  logic [XLEN-1:0] abs_a, abs_b;
  always_comb begin
    in_div      = bus.funct3[2];
    in_signed_a = in_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    in_signed_b = in_div ? ~bus.funct3[0] : ~bus.funct3[1];
    in_sign_a   = in_signed_a & bus.op_a[XLEN-1];
    in_sign_b   = in_signed_b & bus.op_b[XLEN-1];
    abs_a       = in_sign_a ? -bus.op_a : bus.op_a;
    abs_b       = in_sign_b ? -bus.op_b : bus.op_b;
    in_div0     = in_div & (bus.op_b == '0);
    in_ovf      = in_div & ~bus.funct3[0] & (bus.op_a == MIN_NEG) & (bus.op_b == '1);
  end

  // Per-iteration arithmetic and final sign correction.
  logic [XLEN:0]   add_hi, div_shl, div_diff;
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;
  always_comb begin
    add_hi   = {1'b0, prod_q[PW-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
    div_shl  = prod_q[PW-1:XLEN-1];
    div_diff = div_shl - {1'b0, b_q};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
    rem_fix  = sign_a_q ? -prod_q[PW-1:XLEN] : prod_q[PW-1:XLEN];
    if (is_div_q) fix_res = pick_hi_q ? rem_fix : quo_fix;
    else          fix_res = pick_hi_q ? prod_fix[PW-1:XLEN] : prod_fix[XLEN-1:0];
  end

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    pick_hi_d = pick_hi_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
    cnt_d     = cnt_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    result_d  = result_q;
    rd_out_d  = rd_out_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          is_div_d  = in_div;
          pick_hi_d = in_div ? bus.funct3[1] : (bus.funct3[1:0] != 2'b00);
          rd_d      = bus.rd_in;
          a_d       = abs_a;
          b_d       = abs_b;
          sign_a_d  = in_sign_a;
          sign_b_d  = in_sign_b;
          cnt_d     = CNT_W'(XLEN - 1);
          if (in_div0) begin
            result_d = bus.funct3[1] ? bus.op_a : '1;
            rd_out_d = bus.rd_in;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else if (in_ovf) begin
            result_d = bus.funct3[1] ? '0 : bus.op_a;
            rd_out_d = bus.rd_in;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            prod_d  = {{XLEN{1'b0}}, (in_div ? abs_a : abs_b)};
            state_d = in_div ? S_DIV : S_MUL;
          end
        end
      end
      S_MUL: begin
        prod_d = {add_hi, prod_q[XLEN-1:1]};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_DIV: begin
        // High half is the partial remainder, low half shifts dividend out and quotient in.
        if (!div_diff[XLEN]) prod_d = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        else                 prod_d = {prod_q[PW-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_res;
        rd_out_d = rd_q;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      is_div_q  <= 1'b0;
      pick_hi_q <= 1'b0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      result_q  <= '0;
      rd_out_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      pick_hi_q <= pick_hi_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      prod_q    <= prod_d;
      cnt_q     <= cnt_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      result_q  <= result_d;
      rd_out_q  <= rd_out_d;
      done_q    <= done_d;
    end
  end

  // stall depends on the live start/flush so EX freezes in the issue cycle.
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.stall  = ((state_q == S_IDLE) & bus.start & ~bus.flush) |
                      (state_q == S_MUL) | (state_q == S_DIV) | (state_q == S_FIX);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_pl_muldiv_unit.sv
// Scoreboard bench for pl_muldiv_unit at XLEN=32: directed spec cases, random ops,
// flush and asynchronous reset mid-operation.
module tb_pl_muldiv_unit;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic [31:0] last_res = '0;
  exp_t sb[$];
  exp_t mon_e;

  pl_muldiv_unit_if #(.XLEN(32)) bus ();

  pl_muldiv_unit #(.XLEN(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb_, ub, p;
    logic [63:0] up;
    sa  = {{32{a[31]}}, a};
    sb_ = {{32{b[31]}}, b};
    ub  = {32'b0, b};
    case (f3)
      3'd0: begin p = sa * sb_; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        p = sa / sb_; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        p = sa % sb_; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 34;
    if (b == 0) return 1;
    if (!f3[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one op; with hold=1, start stays high the whole time EX is frozen.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res, input bit hold);
    int  lat, stalls;
    bit  seen;
    exp_t e;
    lat = exp_lat(f3, a, b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
    e.res = exp_res;
    e.rd  = rd;
    e.cyc = cyc + lat;
    sb.push_back(e);
    #1;
    stalls = bus.stall ? 1 : 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      #1;
      if (bus.done) begin
        seen = 1'b1;
        bus.start = 1'b0;
        #1;
        check("stall_in_done", 32'(bus.stall), 32'd0);
      end else begin
        stalls += bus.stall ? 1 : 0;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(lat));
  endtask

  // Scoreboard: every done must match the oldest outstanding op.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result", bus.result, mon_e.res);
        check("rd_out", 32'(bus.rd_out), 32'(mon_e.rd));
        check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        last_res = bus.result;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0;
    bus.rd_in = '0;   bus.op_a = '0;    bus.op_b = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy",   32'(bus.busy),   32'd0);
    check("rst_done",   32'(bus.done),   32'd0);
    check("rst_result", bus.result,      32'd0);
    check("rst_rd_out", 32'(bus.rd_out), 32'd0);
    check("rst_stall",  32'(bus.stall),  32'd0);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0);
    run_op(3'd1, MIN_NEG,      MIN_NEG,       5'd6,  32'h4000_0000, 1'b0);
    run_op(3'd3, MIN_NEG,      MIN_NEG,       5'd7,  32'h4000_0000, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,        5'd8,  32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,        5'd9,  32'hFFFF_FFFD, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,        5'd10, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd5, 32'd100,      32'd7,         5'd11, 32'd14,        1'b0);
    run_op(3'd7, 32'd100,      32'd7,         5'd12, 32'd2,         1'b0);
    run_op(3'd5, 32'd5,        32'd0,         5'd13, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'd5,        32'd0,         5'd14, 32'd5,         1'b0);
    run_op(3'd4, MIN_NEG,      32'hFFFF_FFFF, 5'd15, MIN_NEG,       1'b0);
    run_op(3'd6, MIN_NEG,      32'hFFFF_FFFF, 5'd16, 32'd0,         1'b0);

    for (int i = 0; i < 14; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = (i % 5 == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom());
      run_op(f3, a, b, 5'($urandom_range(1, 31)), model(f3, a, b), 1'b0);
    end

    // Flush of a DIV in cycle 10: back to IDLE in cycle 11, no done, result kept.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.rd_in = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_busy",   32'(bus.busy), 32'd0);
    check("flush_done",   32'(bus.done), 32'd0);
    check("flush_result", bus.result,    last_res);
    run_op(3'd5, 32'd1000, 32'd3, 5'd17, 32'd333, 1'b0);

    // start held high for the whole op must give exactly one done.
    run_op(3'd0, 32'd12345, 32'd678, 5'd18, 32'd8369910, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("hold_idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset in cycle 5 of a MUL.
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd5; bus.rd_in = 5'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy",   32'(bus.busy),   32'd0);
    check("arst_done",   32'(bus.done),   32'd0);
    check("arst_result", bus.result,      32'd0);
    check("arst_rd_out", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
